lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store sequencer between the execute stage and the data-memory bus.
- Takes the decoded memory controls (mem_read, mem_write, data_size, data_sign) plus the ALU-computed address and the rs2 store data.
- Runs one req/ack bus transaction per instruction and stalls the pipeline until it completes.
- Aligns and extends load data, generates byte enables, and flags misaligned accesses and bus faults.

Parameters:
- WORD_SIZE, 32, data and address width; only 32 is supported.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before a bus fault is forced; 0 disables the timeout.
- TO_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  EX-stage instruction valid; held while stall=1.
- mem_read  in  1  load request from the decoder.
- mem_write  in  1  store request from the decoder.
- data_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- data_sign  in  1  0 = sign-extend load, 1 = zero-extend load.
- addr  in  WORD_SIZE  effective byte address.
- wdata  in  WORD_SIZE  store data (rs2).
- stall  out  1  hold the pipeline.
- done  out  1  one-cycle pulse: access completed OK.
- rdata  out  WORD_SIZE  aligned, extended load result; valid while done=1.
- misaligned  out  1  one-cycle pulse: alignment fault, no bus cycle issued.
- bus_fault  out  1  one-cycle pulse: bus_err or timeout.
- bus_req  out  1  bus request; held until ack or err.
- bus_we  out  1  1 = write.
- bus_addr  out  WORD_SIZE  word-aligned address: {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  WORD_SIZE  lane-replicated store data.
- bus_ack  in  1  transaction complete; bus_rdata valid.
- bus_rdata  in  WORD_SIZE  read data.
- bus_err  in  1  transaction error; terminates the access.

Behaviour:

States:
- IDLE, ACCESS, DONE, FAULT.
- One clock; rst_n asynchronous, active-low.
- Reset (including mid-access): state=IDLE, timeout counter=0, every registered output = 0. bus_req drops immediately and the transaction is abandoned.

Definitions:
- op = start & (mem_read | mem_write).
- is_wr = mem_write; if mem_read and mem_write are both high, the store wins.

IDLE:
- If op and the access is misaligned (half with addr[0]=1; word with addr[1:0]≠0; data_size=11): go to FAULT with fault cause = misaligned.
- Otherwise, if op: latch addr[1:0], data_size, data_sign, is_wr; register bus_addr, bus_we, bus_be, bus_wdata; set bus_req=1; go to ACCESS.

ACCESS:
- bus_req and the bus_* fields are held constant.
- Timeout counter increments every cycle.
- bus_err=1 (priority over ack): go to FAULT, cause = bus.
- Else bus_ack=1: capture the aligned/extended rdata, go to DONE.
- Else counter == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0): go to FAULT, cause = bus.
- bus_req clears on the same edge the state leaves ACCESS.

DONE:
- done=1 for exactly one cycle, then IDLE.

FAULT:
- misaligned=1 or bus_fault=1 for exactly one cycle (per cause), then IDLE.
- rdata=0.

Start handling:
- start is ignored in DONE and FAULT (it is still high for the same instruction); no re-issue.
- The next op is accepted only in IDLE.

stall (combinational):
- stall = (state==IDLE & op) | (state==ACCESS).
- Low in DONE and FAULT, so the pipeline advances on the DONE/FAULT cycle.

Latency:
- Op at cycle 0, bus_req cycles 1..k, ack in cycle k, done in cycle k+1.
- Minimum is done at cycle 2.

Byte enables:
- byte: 0001<<addr[1:0].
- half: 0011<<{addr[1],1'b0}.
- word: 1111.
- Loads drive the same enables; bus_we=0.

Store data:
- byte: {4{wdata[7:0]}}.
- half: {2{wdata[15:0]}}.
- word: wdata.

Load data:
- Select the byte lane addr[1:0] or half lane addr[1].
- Extend to 32 bits: sign-extend if data_sign=0, zero-extend if 1.
- Word loads pass through.

Timeout counter:
- Cleared on entry to ACCESS; saturates.

Test Plan:
1. LW addr=0x100, ack after 3 wait cycles, bus_rdata=0xDEADBEEF -> bus_addr=0x100, be=1111, stall high 4 cycles + the start cycle, done pulse, rdata=0xDEADBEEF.
2. LB addr=0x203 with bus_rdata=0x80xxxxxx, data_sign=0 -> be=1000, rdata=0xFFFFFF80; repeat as LBU (data_sign=1) -> rdata=0x00000080.
3. SH addr=0x12, wdata=0x0000ABCD -> bus_addr=0x10, be=1100, bus_wdata=0xABCDABCD, we=1, done pulse.
4. LW addr=0x102 -> no bus_req, misaligned pulse 1 cycle after start, stall low afterwards. SH addr=0x3 -> same behaviour.
5. TIMEOUT_CYCLES=4, no ack -> bus_req high 4 cycles, bus_fault pulse, back to IDLE. bus_err together with ack -> bus_fault, no done.
6. rst_n low during ACCESS -> bus_req, stall, done low immediately. After release, a new LW completes normally; start held in DONE is not re-issued (exactly one bus_req per instruction).

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between the load/store sequencer (master) and memory (slave).
// Handshake: master raises bus_req with stable bus_* fields; slave ends it with bus_ack or bus_err.
interface lsu_ctrl_if #(
   parameter int W = 32
);
   logic         bus_req;
   logic         bus_we;
   logic [W-1:0] bus_addr;
   logic [3:0]   bus_be;
   logic [W-1:0] bus_wdata;
   logic         bus_ack;
   logic [W-1:0] bus_rdata;
   logic         bus_err;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata, bus_err
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata, bus_err
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one req/ack bus transaction per EX-stage memory op,
// stalling the pipeline, aligning load data and flagging misaligned/bus faults.
module lsu_ctrl #(
   parameter int WORD_SIZE      = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [1:0]           data_size,
   input  logic                 data_sign,
   input  logic [WORD_SIZE-1:0] addr,
   input  logic [WORD_SIZE-1:0] wdata,
   output logic                 stall,
   output logic                 done,
   output logic [WORD_SIZE-1:0] rdata,
   output logic                 misaligned,
   output logic                 bus_fault,
   output logic [1:0]           dbg_state,
   lsu_ctrl_if.master           bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2,
      S_FAULT  = 2'd3
   } state_t;

   localparam int CW = (TO_W < 1) ? 1 : TO_W;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t               r_state;
   state_t               w_next;
   logic [CW-1:0]        r_cnt;
   logic                 r_cause_mis;
   logic [1:0]           r_off;
   logic [1:0]           r_size;
   logic                 r_sign;
   logic [WORD_SIZE-1:0] r_rdata;
   logic                 r_req;
   logic                 r_we;
   logic [WORD_SIZE-1:0] r_addr;
   logic [3:0]           r_be;
   logic [WORD_SIZE-1:0] r_wdata;

   logic                 w_op;
   logic                 w_mis;
   logic                 w_timeout;
   logic [3:0]           w_be;
   logic [WORD_SIZE-1:0] w_wdata;
   logic [7:0]           w_byte;
   logic [15:0]          w_half;
   logic [WORD_SIZE-1:0] w_ld;

   assign w_op  = start & (mem_read | mem_write);
   assign w_mis = (data_size == 2'b11) |
                  ((data_size == 2'b01) & addr[0]) |
                  ((data_size == 2'b10) & (addr[1:0] != 2'b00));
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = wdata;
      case (data_size)
         2'b00: begin
            w_be    = 4'b0001 << addr[1:0];
            w_wdata = {4{wdata[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << {addr[1], 1'b0};
            w_wdata = {2{wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = wdata;
         end
      endcase
   end

   // Load lane select uses the offset/size/sign latched at issue, not the live inputs.
   always_comb begin
      w_byte = bus.bus_rdata[7:0];
      case (r_off)
         2'd1:    w_byte = bus.bus_rdata[15:8];
         2'd2:    w_byte = bus.bus_rdata[23:16];
         2'd3:    w_byte = bus.bus_rdata[31:24];
         default: w_byte = bus.bus_rdata[7:0];
      endcase
      w_half = r_off[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
      w_ld   = bus.bus_rdata;
      case (r_size)
         2'b00:   w_ld = {{24{~r_sign & w_byte[7]}}, w_byte};
         2'b01:   w_ld = {{16{~r_sign & w_half[15]}}, w_half};
         default: w_ld = bus.bus_rdata;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_op) w_next = w_mis ? S_FAULT : S_ACCESS;
         end
         S_ACCESS: begin
            if (bus.bus_err)      w_next = S_FAULT;
            else if (bus.bus_ack) w_next = S_DONE;
            else if (w_timeout)   w_next = S_FAULT;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_cause_mis <= 1'b0;
         r_off       <= 2'b00;
         r_size      <= 2'b00;
         r_sign      <= 1'b0;
         r_rdata     <= '0;
         r_req       <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_be        <= 4'b0000;
         r_wdata     <= '0;
      end else begin
         r_rdata <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_op) begin
                  if (w_mis) begin
                     r_cause_mis <= 1'b1;
                  end else begin
                     r_off   <= addr[1:0];
                     r_size  <= data_size;
                     r_sign  <= data_sign;
                     r_we    <= mem_write;
                     r_addr  <= {addr[WORD_SIZE-1:2], 2'b00};
                     r_be    <= w_be;
                     r_wdata <= w_wdata;
                     r_req   <= 1'b1;
                     r_cnt   <= '0;
                  end
               end
            end
            S_ACCESS: begin
               if (r_cnt != {CW{1'b1}}) r_cnt <= r_cnt + CW'(1);
               if (w_next != S_ACCESS) r_req <= 1'b0;
               if (w_next == S_FAULT)  r_cause_mis <= 1'b0;
               if (w_next == S_DONE)   r_rdata <= w_ld;
            end
            default: ;
         endcase
      end
   end

   assign stall      = ((r_state == S_IDLE) & w_op) | (r_state == S_ACCESS);
   assign done       = (r_state == S_DONE);
   assign misaligned = (r_state == S_FAULT) & r_cause_mis;
   assign bus_fault  = (r_state == S_FAULT) & ~r_cause_mis;
   assign rdata      = r_rdata;
   assign dbg_state  = r_state;

   assign bus.bus_req   = r_req;
   assign bus.bus_we    = r_we;
   assign bus.bus_addr  = r_addr;
   assign bus.bus_be    = r_be;
   assign bus.bus_wdata = r_wdata;

endmodule
